// File: rtl/clyde_phi_sched.sv
// Sequencer for the masked Clyde tweak-schedule phi unit: walks the tweak
// state index 0..NS (encryption) or pre-rolls to NS and walks back down to 0
// (decryption), presenting each state to the round logic via valid/ack.
`timescale 1ns/1ps

module clyde_phi_sched #(
    parameter int unsigned NS = 6,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          decrypt,
    output logic          busy,
    output logic          tk_valid,
    output logic [CW-1:0] tk_idx,
    input  logic          tk_ack,
    output logic          done,
    output logic          phi_in_valid,
    output logic          phi_enable,
    output logic          phi_inverse
);

    localparam logic [CW-1:0] IDX_LAST = CW'(NS);
    localparam logic [CW-1:0] IDX_PRE_END = CW'(NS - 1);
    localparam logic [CW-1:0] IDX_ZERO = '0;
    localparam logic [CW-1:0] IDX_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PRE  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          done_q, done_d;
    logic          is_last;

    // State, counter, direction and done pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Final state of the walk: top index going up, zero going down
    assign is_last = dir_q ? (cnt_q == IDX_ZERO) : (cnt_q == IDX_LAST);

    // Next-state logic and phi unit strobes
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        busy         = 1'b0;
        tk_valid     = 1'b0;
        tk_idx       = '0;
        phi_in_valid = 1'b0;
        phi_enable   = 1'b0;
        phi_inverse  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_d   = decrypt;
                    cnt_d   = '0;
                    state_d = decrypt ? S_PRE : S_LOAD;
                end
            end

            S_LOAD: begin
                busy         = 1'b1;
                tk_valid     = 1'b1;
                phi_in_valid = 1'b1;
                if (tk_ack) begin
                    phi_enable = 1'b1;
                    cnt_d      = IDX_ONE;
                    state_d    = S_RUN;
                end
            end

            S_PRE: begin
                busy         = 1'b1;
                phi_enable   = 1'b1;
                phi_in_valid = (cnt_q == IDX_ZERO);
                if (cnt_q == IDX_PRE_END) begin
                    cnt_d   = IDX_LAST;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + IDX_ONE;
                end
            end

            S_RUN: begin
                busy     = 1'b1;
                tk_valid = 1'b1;
                tk_idx   = cnt_q;
                if (tk_ack) begin
                    if (is_last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        phi_enable  = 1'b1;
                        phi_inverse = dir_q;
                        cnt_d       = dir_q ? (cnt_q - IDX_ONE) : (cnt_q + IDX_ONE);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_clyde_phi_sched.sv
// Self-checking bench for clyde_phi_sched with a behavioural phi unit.
`timescale 1ns/1ps

module tb_clyde_phi_sched;

    localparam int unsigned NS = 6;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          decrypt;
    logic          busy;
    logic          tk_valid;
    logic [CW-1:0] tk_idx;
    logic          tk_ack;
    logic          done;
    logic          phi_in_valid;
    logic          phi_enable;
    logic          phi_inverse;

    logic [15:0]   t_in;
    logic [15:0]   phi_reg;
    logic [15:0]   phi_src;
    logic [15:0]   phi_out;

    int n_checks;
    int n_fail;

    clyde_phi_sched #(.NS(NS), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .busy         (busy),
        .tk_valid     (tk_valid),
        .tk_idx       (tk_idx),
        .tk_ack       (tk_ack),
        .done         (done),
        .phi_in_valid (phi_in_valid),
        .phi_enable   (phi_enable),
        .phi_inverse  (phi_inverse)
    );

    always #5 clk = ~clk;

    // Stand-in phi permutation: rotate left by one, then xor a constant
    function automatic logic [15:0] phi_fn(input logic [15:0] x);
        return {x[14:0], x[15]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] phi_inv(input logic [15:0] y);
        logic [15:0] z;
        z = y ^ 16'h5A3C;
        return {z[0], z[15:1]};
    endfunction

    function automatic logic [15:0] phi_pow(input logic [15:0] t, input int k);
        logic [15:0] r;
        r = t;
        for (int i = 0; i < k; i++) r = phi_fn(r);
        return r;
    endfunction

    // Behavioural phi unit driven by the scheduler strobes
    assign phi_src = phi_in_valid ? t_in : phi_reg;
    assign phi_out = phi_src;

    always_ff @(posedge clk) begin
        if (phi_enable) phi_reg <= phi_inverse ? phi_inv(phi_src) : phi_fn(phi_src);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_tk_valid"}, int'(tk_valid), 0);
        check({tag, "_tk_idx"}, int'(tk_idx), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_phi_in_valid"}, int'(phi_in_valid), 0);
        check({tag, "_phi_enable"}, int'(phi_enable), 0);
        check({tag, "_phi_inverse"}, int'(phi_inverse), 0);
    endtask

    // One schedule from start to done; the index order comes from a queue
    // built straight from the walk direction, phi outputs from phi_pow.
    task automatic run_sched(input bit dec, input int pct, input int exp_first,
                             input int exp_en, input logic [15:0] tval,
                             input bit pre_started);
        int q[$];
        int en_cnt;
        bit fin;
        bit ev, ee, ei, ein;
        en_cnt = 0;
        fin = 1'b0;
        for (int k = 0; k <= int'(NS); k++) q.push_back(dec ? int'(NS) - k : k);
        if (!pre_started) begin
            @(posedge clk); #1;
            start = 1'b1; decrypt = dec; t_in = tval; tk_ack = 1'b0;
            @(negedge clk);
            check("start_cycle_busy", int'(busy), 0);
        end
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            start   = !fin && ($urandom_range(7) == 0);
            decrypt = 1'($urandom);
            if (fin)          tk_ack = 1'b0;
            else if (pct == 0) tk_ack = 1'b1;
            else              tk_ack = ($urandom_range(99) >= 32'(pct));
            @(negedge clk);
            if (fin) begin
                check("done_pulse", int'(done), 1);
                check("done_busy", int'(busy), 0);
                check("done_tk_valid", int'(tk_valid), 0);
                check("enable_count", en_cnt, exp_en);
                return;
            end
            ev  = (cyc >= exp_first);
            ee  = ev ? (tk_ack && q.size() > 1) : 1'b1;
            ei  = ev && ee && dec;
            ein = dec ? (cyc == 1) : (q[0] == 0);
            check("busy", int'(busy), 1);
            check("done_early", int'(done), 0);
            check("tk_valid", int'(tk_valid), int'(ev));
            if (ev) begin
                check("tk_idx", int'(tk_idx), q[0]);
                check("phi_out", int'(phi_out), int'(phi_pow(tval, q[0])));
            end
            check("phi_enable", int'(phi_enable), int'(ee));
            check("phi_inverse", int'(phi_inverse), int'(ei));
            check("phi_in_valid", int'(phi_in_valid), int'(ein));
            if (phi_enable) en_cnt++;
            if (ev && tk_ack) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    fin = 1'b1;
                    if (pct == 0) check("last_ack_cycle", cyc, exp_first + int'(NS));
                end
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL schedule_timeout: no done within 400 cycles (dec=%0d)", dec);
    endtask

    typedef struct {
        bit dec;
        int pct;
        int first;
        int en;
    } vec_t;

    vec_t vecs[4];
    bit   d;
    bit   found;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; tk_ack = 1'b0; t_in = '0;

        vecs[0] = '{dec: 1'b0, pct: 0,  first: 1,          en: int'(NS)};
        vecs[1] = '{dec: 1'b1, pct: 0,  first: int'(NS)+1, en: 2*int'(NS)};
        vecs[2] = '{dec: 1'b0, pct: 50, first: 1,          en: int'(NS)};
        vecs[3] = '{dec: 1'b1, pct: 50, first: int'(NS)+1, en: 2*int'(NS)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // ack while idle must not move anything
        tk_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("idle_ack");
        end
        tk_ack = 1'b0;

        for (int i = 0; i < 4; i++)
            run_sched(vecs[i].dec, vecs[i].pct, vecs[i].first, vecs[i].en,
                      16'h1000 + 16'(i * 16'h0123), 1'b0);

        // start in the done cycle chains straight into a new schedule
        run_sched(1'b0, 0, 1, int'(NS), 16'h1234, 1'b0);
        start = 1'b1; decrypt = 1'b1; t_in = 16'hBEEF; tk_ack = 1'b0;
        run_sched(1'b1, 0, int'(NS)+1, 2*int'(NS), 16'hBEEF, 1'b1);

        for (int i = 0; i < 16; i++) begin
            d = 1'($urandom);
            run_sched(d, 50, d ? int'(NS)+1 : 1, d ? 2*int'(NS) : int'(NS),
                      16'($urandom), 1'b0);
        end

        // reset during a decryption walk at index 3
        @(posedge clk); #1;
        start = 1'b1; decrypt = 1'b1; t_in = 16'hC0DE; tk_ack = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (tk_valid && tk_idx == 3'd3) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL rst_reach_idx3: index 3 never presented");
        end
        rst = 1'b1; tk_ack = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_done", int'(done), 0);
            check("post_rst_busy", int'(busy), 0);
        end
        run_sched(1'b0, 0, 1, int'(NS), 16'h0F0F, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
